// File: rtl/universal_shift_register_seq.sv
// Universal WIDTH-bit shift register: hold/shift/load/rotate/asr plus a sequenced N-step command.
// Latency: direct ops take effect 1 cycle after the edge; a sequence of count steps ends count+1 edges after start.
// Backpressure: en=0 freezes direct ops and stalls a running sequence; start is dropped while busy.
module universal_shift_register_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             ser_in_r,
   input  logic             ser_in_l,
   input  logic [WIDTH-1:0] d,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] q,
   output logic             ser_out_r,
   output logic             ser_out_l,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] M_HOLD = 3'b000;
   localparam logic [2:0] M_SHR  = 3'b001;
   localparam logic [2:0] M_SHL  = 3'b010;
   localparam logic [2:0] M_LOAD = 3'b011;
   localparam logic [2:0] M_ROR  = 3'b100;
   localparam logic [2:0] M_ROL  = 3'b101;
   localparam logic [2:0] M_ASR  = 3'b110;

   logic [CNT_W-1:0] step_cnt;
   logic [2:0]       seq_mode;
   logic [2:0]       op_mode;
   logic [WIDTH-1:0] q_next;
   logic             start_ok;

   // Only shift/rotate modes can be sequenced; HOLD, LOAD and reserved fall back to a direct op.
   assign start_ok = start && !busy &&
                     (mode == M_SHR || mode == M_SHL || mode == M_ROR ||
                      mode == M_ROL || mode == M_ASR);

   // A running sequence uses the mode latched at start; otherwise the live mode input.
   assign op_mode = busy ? seq_mode : mode;

   // One step of the selected operation, shared by direct and sequenced paths.
   always_comb begin
      q_next = q;
      case (op_mode)
         M_SHR:   q_next = {ser_in_r, q[WIDTH-1:1]};
         M_SHL:   q_next = {q[WIDTH-2:0], ser_in_l};
         M_LOAD:  q_next = d;
         M_ROR:   q_next = {q[0], q[WIDTH-1:1]};
         M_ROL:   q_next = {q[WIDTH-2:0], q[WIDTH-1]};
         M_ASR:   q_next = {q[WIDTH-1], q[WIDTH-1:1]};
         default: q_next = q;
      endcase
   end

   // Register, step counter and handshake; reset aborts any sequence without a done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q        <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         step_cnt <= '0;
         seq_mode <= M_HOLD;
      end else begin
         done <= 1'b0;
         if (busy) begin
            if (en && step_cnt != '0) begin
               q        <= q_next;
               step_cnt <= step_cnt - 1'b1;
               if (step_cnt == CNT_W'(1)) begin
                  busy <= 1'b0;
                  done <= 1'b1;
               end
            end
         end else if (start_ok) begin
            // Acceptance edge only latches; q is untouched until the first step edge.
            step_cnt <= count;
            seq_mode <= mode;
            if (count == '0) begin
               done <= 1'b1;
            end else begin
               busy <= 1'b1;
            end
         end else if (en) begin
            q <= q_next;
         end
      end
   end

   // Serial taps are the bits that leave on a right or left shift.
   assign ser_out_r = q[0];
   assign ser_out_l = q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_register_seq.sv
module tb_universal_shift_register_seq;

   localparam int W  = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic [2:0]    mode;
   logic          ser_in_r;
   logic          ser_in_l;
   logic [W-1:0]  d;
   logic          start;
   logic [CW-1:0] count;
   logic [W-1:0]  q;
   logic          ser_out_r;
   logic          ser_out_l;
   logic          busy;
   logic          done;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [W-1:0] m_q;
   int           m_left;
   logic [2:0]   m_mode;
   logic         m_done;

   always #5 clk = ~clk;

   universal_shift_register_seq #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
      .ser_in_r(ser_in_r), .ser_in_l(ser_in_l), .d(d),
      .start(start), .count(count), .q(q),
      .ser_out_r(ser_out_r), .ser_out_l(ser_out_l),
      .busy(busy), .done(done)
   );

   typedef struct {
      logic          en;
      logic [2:0]    mode;
      logic          sr;
      logic          sl;
      logic [W-1:0]  d;
      logic          start;
      logic [CW-1:0] count;
      logic [W-1:0]  eq;
      logic          eb;
      logic          ed;
   } vec_t;

   vec_t tbl[14];

   function automatic logic [W-1:0] ref_op(input logic [2:0] md, input logic [W-1:0] cur,
                                           input logic sr, input logic sl, input logic [W-1:0] dd);
      logic [W-1:0] r;
      logic [W-1:0] top;
      top = W'(1) << (W - 1);
      case (md)
         3'd1:    r = (cur / 2) + (sr ? top : '0);
         3'd2:    r = W'(cur * 2) + W'(sl);
         3'd3:    r = dd;
         3'd4:    r = (cur / 2) + (cur[0] ? top : '0);
         3'd5:    r = W'(cur * 2) + W'(cur[W-1]);
         3'd6:    r = (cur / 2) + (cur[W-1] ? top : '0);
         default: r = cur;
      endcase
      return r;
   endfunction

   function automatic bit is_seq(input logic [2:0] md);
      return md inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_q = '0; m_left = 0; m_mode = 3'd0; m_done = 1'b0;
   endtask

   // Advance one clock, updating the model from the inputs present before the edge.
   task automatic cycle();
      m_done = 1'b0;
      if (m_left > 0) begin
         if (en) begin
            m_q = ref_op(m_mode, m_q, ser_in_r, ser_in_l, d);
            m_left--;
            if (m_left == 0) m_done = 1'b1;
         end
      end else if (start && is_seq(mode)) begin
         m_mode = mode;
         if (count == 0) m_done = 1'b1;
         else m_left = int'(count);
      end else if (en) begin
         m_q = ref_op(mode, m_q, ser_in_r, ser_in_l, d);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_q"},    32'(q),         32'(m_q));
      chk({tag, "_busy"}, 32'(busy),      32'(m_left > 0));
      chk({tag, "_done"}, 32'(done),      32'(m_done));
      chk({tag, "_sor"},  32'(ser_out_r), 32'(m_q[0]));
      chk({tag, "_sol"},  32'(ser_out_l), 32'(m_q[W-1]));
   endtask

   task automatic drive(input logic e, input logic [2:0] md, input logic sr, input logic sl,
                        input logic [W-1:0] dd, input logic st, input logic [CW-1:0] c);
      en = e; mode = md; ser_in_r = sr; ser_in_l = sl; d = dd; start = st; count = c;
   endtask

   int busy_cycles;
   int done_cycles;

   initial begin
      tbl[0]  = '{1'b1, 3'd3, 1'b0, 1'b0, 8'hA5, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 3'd6, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 8'hD2, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 3'd1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 8'h69, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 3'd2, 1'b0, 1'b1, 8'h00, 1'b0, 4'd0, 8'hD3, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 3'd4, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 8'hE9, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 3'd1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 8'hE9, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 3'd3, 1'b0, 1'b0, 8'h81, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 3'd5, 1'b0, 1'b0, 8'h00, 1'b1, 4'd3, 8'h81, 1'b1, 1'b0};
      tbl[8]  = '{1'b1, 3'd5, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 8'h03, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 3'd5, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 8'h06, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 3'd5, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 8'h0C, 1'b0, 1'b1};
      tbl[11] = '{1'b1, 3'd1, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 8'h0C, 1'b0, 1'b1};
      tbl[12] = '{1'b1, 3'd3, 1'b0, 1'b0, 8'h3C, 1'b1, 4'd5, 8'h3C, 1'b0, 1'b0};
      tbl[13] = '{1'b1, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 8'h3C, 1'b0, 1'b0};

      // Reset: async assertion between edges clears a loaded register at once
      rst_n = 1'b0;
      drive(1'b0, 3'd0, 1'b0, 1'b0, '0, 1'b0, '0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 3'd3, 1'b0, 1'b0, 8'h5A, 1'b0, '0);
      cycle();
      check_model("pre_rst");
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_rst_q", 32'(q), 32'h0);
      chk("async_rst_busy", 32'(busy), 32'h0);
      chk("async_rst_done", 32'(done), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 3'd3, 1'b0, 1'b0, 8'hFF, 1'b0, '0);
      cycle();
      check_model("rst_release");

      // Direct ops, first sequence, zero count and rejected start
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].en, tbl[i].mode, tbl[i].sr, tbl[i].sl, tbl[i].d, tbl[i].start, tbl[i].count);
         cycle();
         chk($sformatf("tbl%0d_q", i), 32'(q), 32'(tbl[i].eq));
         chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].eb));
         chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].ed));
         check_model($sformatf("tbl%0d_m", i));
      end

      // Stall and ignore: ASR x4 from 0x80 with 2 stall cycles and a LOAD start during busy
      drive(1'b1, 3'd3, 1'b0, 1'b0, 8'h80, 1'b0, '0);
      cycle();
      busy_cycles = 0; done_cycles = 0;
      drive(1'b1, 3'd6, 1'b0, 1'b0, 8'h00, 1'b1, 4'd4);
      for (int i = 0; i < 8; i++) begin
         cycle();
         check_model($sformatf("stall%0d", i));
         if (busy) busy_cycles++;
         if (done) done_cycles++;
         if (i == 0) drive(1'b1, 3'd3, 1'b0, 1'b0, 8'h55, 1'b0, '0);
         if (i == 1) begin
            chk("stall_first_step", 32'(q), 32'hC0);
            drive(1'b0, 3'd3, 1'b0, 1'b0, 8'h55, 1'b1, 4'd2);
         end
         if (i == 2) drive(1'b0, 3'd3, 1'b0, 1'b0, 8'h55, 1'b0, '0);
         if (i == 3) begin
            chk("stall_hold", 32'(q), 32'hC0);
            drive(1'b1, 3'd3, 1'b0, 1'b0, 8'h55, 1'b1, 4'd1);
         end
         if (i == 4) drive(1'b1, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, '0);
      end
      chk("stall_final_q", 32'(q), 32'hF8);
      chk("stall_busy_cycles", 32'(busy_cycles), 32'd6);
      chk("stall_done_count", 32'(done_cycles), 32'd1);

      // Reset mid-sequence: SHL x10 aborted after 3 steps
      drive(1'b1, 3'd3, 1'b0, 1'b0, 8'h01, 1'b0, '0);
      cycle();
      drive(1'b1, 3'd2, 1'b0, 1'b1, 8'h00, 1'b1, 4'd10);
      cycle();
      drive(1'b1, 3'd2, 1'b0, 1'b1, 8'h00, 1'b0, '0);
      for (int i = 0; i < 3; i++) cycle();
      chk("midseq_q", 32'(q), 32'h0F);
      chk("midseq_busy", 32'(busy), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("abort_q", 32'(q), 32'h0);
      chk("abort_busy", 32'(busy), 32'h0);
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'h0);
      rst_n = 1'b1;
      drive(1'b0, 3'd2, 1'b0, 1'b1, 8'h00, 1'b0, '0);
      cycle();
      check_model("abort_after");
      drive(1'b1, 3'd3, 1'b0, 1'b0, 8'h0F, 1'b0, '0);
      cycle();
      drive(1'b1, 3'd4, 1'b0, 1'b0, 8'h00, 1'b1, 4'd2);
      for (int i = 0; i < 3; i++) begin
         cycle();
         check_model($sformatf("rerun%0d", i));
         drive(1'b1, 3'd4, 1'b0, 1'b0, 8'h00, 1'b0, '0);
      end
      chk("rerun_final_q", 32'(q), 32'hC3);
      chk("rerun_done", 32'(done), 32'h1);

      // Randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)),
               1'($urandom), 1'($urandom), W'($urandom),
               ($urandom_range(0, 3) == 0), CW'($urandom_range(0, 15)));
         cycle();
         check_model($sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Safety net against a hung run
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/universal_shift_register_seq.md
Name: universal_shift_register_seq

Overview:
Parametrised universal shift register that generalises the fixed 4-bit hold/shift/load register to WIDTH bits. It adds rotate and arithmetic-shift modes, serial outputs, and a sequenced multi-step command. The command runs N shift/rotate steps, one per cycle, under a start/busy/done handshake. It sits in the datapath library as the generic serialiser/barrel-step element for UART/SPI-style framing and bit-manipulation blocks.

Parameters:
WIDTH, 8, register width in bits (>= 2)
CNT_W, 4, width of step-count input; max sequenced steps = 2^CNT_W - 1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  clock enable for direct ops; while busy, en=0 pauses the sequence
mode  input  3  operation select (encoding below)
ser_in_r  input  1  serial bit entering MSB on right shift
ser_in_l  input  1  serial bit entering LSB on left shift
d  input  WIDTH  parallel load data
start  input  1  launch sequenced command (sampled only when busy=0)
count  input  CNT_W  number of steps for sequenced command
q  output  WIDTH  register contents
ser_out_r  output  1  q[0] (bit shifted out on right shift)
ser_out_l  output  1  q[WIDTH-1] (bit shifted out on left shift)
busy  output  1  sequenced command in progress
done  output  1  one-cycle pulse on command completion

Behaviour:
- Reset: rst_n low immediately forces q=0, busy=0, done=0, internal step counter=0 and latched mode=000, regardless of clk. This applies mid-sequence too; no done is produced for an aborted command.
- Mode encoding, applied as one step at a clock edge:
  - 000 HOLD: q unchanged.
  - 001 SHR: q <= {ser_in_r, q[W-1:1]}.
  - 010 SHL: q <= {q[W-2:0], ser_in_l}.
  - 011 LOAD: q <= d.
  - 100 ROR: q <= {q[0], q[W-1:1]}.
  - 101 ROL: q <= {q[W-2:0], q[W-1]}.
  - 110 ASR: q <= {q[W-1], q[W-1:1]}.
  - 111: reserved, behaves as HOLD.
- Direct operation (busy=0, start=0): at each edge with en=1, apply mode. With en=0, q holds. Latency is 1 cycle.
- Sequenced command: start=1 while busy=0 and mode in {001,010,100,101,110} is accepted at edge T.
  - At T: the step counter latches count and the latched mode latches mode. q is NOT modified at T.
  - count>0: busy<=1 at T. At each following edge with en=1, apply latched mode and decrement the counter.
  - The edge that decrements 1->0 performs the final step, sets busy<=0 and sets done<=1.
  - With en high throughout, steps occur at T+1..T+count. busy is high for exactly count cycles. done is high for the single cycle after T+count.
  - count=0: busy stays 0, q unchanged, done<=1 at T (one-cycle pulse).
- While busy:
  - en=0 stalls: no step, counter holds, busy stays 1.
  - mode, d and start are ignored. start during busy is dropped, not queued.
  - ser_in_r/ser_in_l are sampled live on each step edge.
- start=1 with mode in {000,011,111}: not accepted. The cycle behaves as a direct op (en gating applies), with no busy and no done.
- done is 0 in every cycle other than the completion pulse. A new start may be accepted in the same cycle done is high (busy=0).
- ser_out_r and ser_out_l are combinational taps of q. Their reset value is 0.
- Counter width is CNT_W. No wrap: the counter never decrements below 0.

Test Plan:
1. Reset: drive rst_n=0 asynchronously between edges -> q=0x00, busy=0, done=0 immediately; release with en=0 -> q stays 0x00.
2. Direct ops (WIDTH=8): LOAD d=0xA5 -> q=0xA5; ASR -> 0xD2; SHR ser_in_r=0 -> 0x69; SHL ser_in_l=1 -> 0xD3; ROR -> 0xE9; en=0 with mode=SHR -> q stays 0xE9.
3. Sequence: q=0x81, start, mode=ROL, count=3 -> no change at T; q=0x03, 0x06, 0x0C on the next three edges; busy=1 for 3 cycles; done=1 for one cycle after the third step; ser_out_l=0.
4. Zero count and rejects: start with count=0, mode=SHR -> done pulse next cycle, busy=0, q unchanged. start with mode=LOAD, d=0x3C -> q=0x3C, no busy, no done.
5. Stall and ignore: q=0x80, start ASR count=4. Drop en for 2 cycles after the first step, and pulse start with mode=LOAD. Expected: q=0xC0 holds during the stall, LOAD is ignored, final q=0xF8, busy high for 6 cycles total, single done.
6. Reset mid-sequence: start SHL count=10 and assert rst_n=0 after 3 steps -> q=0, busy=0 at once, no done. A new command after release runs normally.
